// File: rtl/hamming_decoder_pipe.sv
// Two-stage pipelined Hamming SEC decoder for 38-bit codewords.
// Valid/ready on both sides, saturating corrected/uncorrectable counters.
module hamming_decoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [37:0]      enc_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      data,
  output logic             err_corrected,
  output logic             err_uncorr,
  output logic [5:0]       syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  typedef struct packed {
    logic [37:0] code;
    logic [5:0]  syn;
  } s1_t;

  typedef struct packed {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
    logic [5:0]  syn;
  } s2_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  logic        s2_adv;
  logic        s1_adv;
  logic        accept;
  logic        fire_out;
  logic [5:0]  syn_raw;
  logic [37:0] fix;
  logic [37:0] fixed_code;
  logic        dec_corr;
  logic        dec_uncorr;

  // Syndrome bit k covers every position p with bit k of p set.
  for (genvar k = 0; k < 6; k++) begin : g_syn
    logic [37:0] m;
    for (genvar i = 0; i < 38; i++) begin : g_bit
      if (((i + 1) >> k) % 2 == 1) begin : g_on
        assign m[i] = enc_data[i];
      end else begin : g_off
        assign m[i] = 1'b0;
      end
    end
    assign syn_raw[k] = ^m;
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;
  assign fire_out = s2_valid_q && out_ready;

  // Stage 1 next state: capture codeword and its syndrome.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_d.code = enc_data;
      s1_d.syn  = syn_raw;
    end
  end

  // Classify the stage-1 syndrome and build the correction mask.
  always_comb begin
    fix        = '0;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    unique case (1'b1)
      (s1_q.syn == 6'd0): begin
      end
      (s1_q.syn != 6'd0 && s1_q.syn <= 6'd38): begin
        dec_corr = 1'b1;
        fix      = 38'd1 << (s1_q.syn - 6'd1);
      end
      (s1_q.syn > 6'd38): begin
        dec_uncorr = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign fixed_code = s1_q.code ^ fix;

  // Stage 2 next state: register the extracted data and flags.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d.data = {fixed_code[37:32],
                     fixed_code[30:16],
                     fixed_code[14:8],
                     fixed_code[6:4],
                     fixed_code[2]};
        s2_d.corr   = dec_corr;
        s2_d.uncorr = dec_uncorr;
        s2_d.syn    = s1_q.syn;
      end
    end
  end

  // Event counters: clear wins, otherwise saturating increment on transfer.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (fire_out) begin
      if (s2_q.corr && !(&corr_cnt_q)) begin
        corr_cnt_d = corr_cnt_q + 1'b1;
      end
      if (s2_q.uncorr && !(&uncorr_cnt_q)) begin
        uncorr_cnt_d = uncorr_cnt_q + 1'b1;
      end
    end
  end

  // Pipeline and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_q         <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      s2_q         <= s2_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign data          = s2_q.data;
  assign err_corrected = s2_q.corr;
  assign err_uncorr    = s2_q.uncorr;
  assign syndrome      = s2_q.syn;
  assign corr_cnt      = corr_cnt_q;
  assign uncorr_cnt    = uncorr_cnt_q;

endmodule
